button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Parametrised input front-end for the player controls (left, right, and future buttons) feeding the game core, which runs on clk50mhz.
- Per channel: synchronises the raw asynchronous button, debounces it, and produces a clean level plus single-cycle press, release and auto-repeat strobes.
- Generalises the current two-input arrangement to CHANNELS inputs, adds a configurable debounce interval, and adds a per-channel auto-repeat mode for held steering.

Parameters:
- CHANNELS, 2, number of independent button channels (bit 0 = left, bit 1 = right).
- DEBOUNCE_CYCLES, 500000, number of consecutive stable synchronised samples required to accept a change (10 ms at 50 MHz); minimum 1.
- REPEAT_DELAY, 12500000, cycles from the press strobe to the first auto-repeat strobe; minimum 1.
- REPEAT_PERIOD, 2500000, cycles between subsequent auto-repeat strobes; minimum 1.
- CNT_W, derived as clog2 of the maximum of the three counts plus 1, width of the per-channel counters. Not to be overridden.

Ports:
- clk50mhz  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- btn_raw  in  CHANNELS  raw button inputs, active-high, asynchronous to clk50mhz.
- repeat_en  in  CHANNELS  per-channel auto-repeat enable, synchronous.
- btn_level  out  CHANNELS  debounced button level.
- btn_press  out  CHANNELS  one-cycle strobe on a debounced 0->1 transition.
- btn_release  out  CHANNELS  one-cycle strobe on a debounced 1->0 transition.
- btn_repeat  out  CHANNELS  one-cycle strobe on press and on each auto-repeat.

Behaviour:
- Reset (reset=0, asynchronous): synchronisers, stable levels and counters go to 0; repeat FSM goes to IDLE; every output is 0.
- Synchroniser: two flops per channel (s1, s2). s2 is the sampled value.
- Debounce, per channel:
  - If s2 == stable, the debounce counter clears.
  - Otherwise the counter increments. When the counter equals DEBOUNCE_CYCLES-1 and s2 still differs from stable, stable takes s2 and the counter clears on the same edge.
  - Any glitch that returns s2 to the stable value before the count completes clears the counter and produces no output.
- Latency: a raw change that is steady from clock edge E updates btn_level at edge E+DEBOUNCE_CYCLES+1.
- Strobes:
  - btn_press and btn_release are registered and assert on the same edge that stable changes, for exactly one cycle.
  - btn_level equals stable.
- Repeat FSM, per channel, with states IDLE, DELAY and REPEAT:
  - IDLE: on a press, assert btn_repeat. If repeat_en=1, load the counter with REPEAT_DELAY-1 and go to DELAY; otherwise stay in IDLE.
  - DELAY: decrement the counter. When it reaches 0, pulse btn_repeat, load REPEAT_PERIOD-1 and go to REPEAT.
  - REPEAT: decrement the counter. When it reaches 0, pulse btn_repeat and reload REPEAT_PERIOD-1.
  - Resulting strobe times: the press cycle T, then T+REPEAT_DELAY, T+REPEAT_DELAY+REPEAT_PERIOD, and so on.
  - A release in DELAY or REPEAT returns the FSM to IDLE on that edge. No repeat strobe is issued that cycle, even if the counter hits 0.
  - Deasserting repeat_en in DELAY or REPEAT returns the FSM to IDLE on the next edge with no strobe. Reasserting it while held does not restart repeats until the next press.
- Channels are fully independent. Simultaneous presses on several channels each produce their own strobes in the same cycle.
- Counters never wrap: the debounce counter is bounded by DEBOUNCE_CYCLES-1, and the repeat counter reloads at 0.
- Reset mid-operation: everything clears immediately. If a button is held through reset release, it is treated as a new press after DEBOUNCE_CYCLES+1 edges.
- Press and release cannot coincide on one channel, because stable changes at most once per edge.

Decomposition:
- Shared package holds the repeat-state encoding (IDLE=2'd0, DELAY=2'd1, REPEAT=2'd2) and the CNT_W derivation function.
- Sub-module button_channel holds one synchroniser, debouncer and repeat FSM.
- button_conditioner instantiates CHANNELS copies of button_channel in a generate loop.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3 and CHANNELS=2.
1. Reset held low with btn_raw=2'b11 -> all outputs 0. Release reset -> btn_level=2'b11 and btn_press=2'b11 for one cycle, 5 edges after release.
2. btn_raw[0] pulses high for 3 cycles -> no change on btn_level[0], and no press, release or repeat strobe.
3. btn_raw[0] held high, repeat_en=0 -> exactly one btn_press and one btn_repeat, then nothing. Drop btn_raw -> btn_release 5 edges later.
4. btn_raw[1] held for 30 cycles, repeat_en=1 -> btn_repeat at T, T+8, T+11, T+14, T+17 and so on while held. On release, the FSM returns to IDLE with no further strobes.
5. Release while in DELAY, at T+6 as seen at btn_level -> no repeat strobe at T+8. A fresh press restarts timing from a new T.
6. Both channels pressed in the same cycle, with reset asserted at T+9 -> outputs 0 immediately, FSMs in IDLE, and no strobes until the re-debounced press.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the button front-end: repeat FSM encoding and
// the counter-width derivation used by every channel.
package button_conditioner_pkg;

    localparam logic [1:0] RPT_IDLE   = 2'd0;
    localparam logic [1:0] RPT_DELAY  = 2'd1;
    localparam logic [1:0] RPT_REPEAT = 2'd2;

    // Wide enough for the largest of the three intervals, with one spare bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: two-flop synchroniser, debouncer, press/release
// strobes and the auto-repeat FSM.
//
//  state      | meaning
//  -----------+--------------------------------------------------------
//  RPT_IDLE   | waiting for a debounced press
//  RPT_DELAY  | held with repeat enabled, counting down to first repeat
//  RPT_REPEAT | held, issuing a repeat strobe every REPEAT_PERIOD cycles
module button_channel #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 2500000,
    parameter int CNT_W           = 25
) (
    input  logic clk50mhz,
    input  logic reset,
    input  logic btn_raw,
    input  logic repeat_en,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);
    import button_conditioner_pkg::*;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LOAD = CNT_W'(REPEAT_PERIOD - 1);

    logic             s1;
    logic             s2;
    logic             stable;
    logic [CNT_W-1:0] db_cnt;
    logic [CNT_W-1:0] rpt_cnt;
    logic [1:0]       rpt_state;
    logic             db_done;
    logic             rise;
    logic             fall;

    // The FSM reacts to the same edge that commits the debounced change,
    // so the first repeat strobe lines up with btn_press.
    assign db_done = (s2 != stable) && (db_cnt == DB_LAST);
    assign rise    = db_done & s2;
    assign fall    = db_done & ~s2;

    assign btn_level = stable;

    always_ff @(posedge clk50mhz or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk50mhz or negedge reset) begin
        if (!reset) begin
            stable      <= 1'b0;
            db_cnt      <= '0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            btn_press   <= rise;
            btn_release <= fall;
            if (s2 == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                stable <= s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk50mhz or negedge reset) begin
        if (!reset) begin
            rpt_state  <= RPT_IDLE;
            rpt_cnt    <= '0;
            btn_repeat <= 1'b0;
        end else begin
            btn_repeat <= 1'b0;
            case (rpt_state)
                RPT_IDLE: begin
                    if (rise) begin
                        btn_repeat <= 1'b1;
                        if (repeat_en) begin
                            rpt_cnt   <= RD_LOAD;
                            rpt_state <= RPT_DELAY;
                        end
                    end
                end
                RPT_DELAY, RPT_REPEAT: begin
                    // Release or disable wins over a coincident terminal count.
                    if (fall || !repeat_en) begin
                        rpt_state <= RPT_IDLE;
                        rpt_cnt   <= '0;
                    end else if (rpt_cnt == '0) begin
                        btn_repeat <= 1'b1;
                        rpt_cnt    <= RP_LOAD;
                        rpt_state  <= RPT_REPEAT;
                    end else begin
                        rpt_cnt <= rpt_cnt - 1'b1;
                    end
                end
                default: begin
                    rpt_state <= RPT_IDLE;
                    rpt_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Player-control input front-end: CHANNELS independent synchronise /
// debounce / auto-repeat channels feeding the game core.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int CHANNELS        = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 2500000
) (
    input  logic                clk50mhz,
    input  logic                reset,
    input  logic [CHANNELS-1:0] btn_raw,
    input  logic [CHANNELS-1:0] repeat_en,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_press,
    output logic [CHANNELS-1:0] btn_release,
    output logic [CHANNELS-1:0] btn_repeat
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk50mhz   (clk50mhz),
            .reset      (reset),
            .btn_raw    (btn_raw[i]),
            .repeat_en  (repeat_en[i]),
            .btn_level  (btn_level[i]),
            .btn_press  (btn_press[i]),
            .btn_release(btn_release[i]),
            .btn_repeat (btn_repeat[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short intervals
// (debounce 4, repeat delay 8, repeat period 3).
module tb_button_conditioner;

    logic       clk50mhz = 1'b0;
    logic       reset;
    logic [1:0] btn_raw;
    logic [1:0] repeat_en;
    logic [1:0] btn_level;
    logic [1:0] btn_press;
    logic [1:0] btn_release;
    logic [1:0] btn_repeat;

    int total = 0;
    int bad   = 0;

    button_conditioner #(
        .CHANNELS       (2),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (8),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clk50mhz   (clk50mhz),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .repeat_en  (repeat_en),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_repeat (btn_repeat)
    );

    always #5 clk50mhz = ~clk50mhz;

    // One clock edge, then settle to the falling edge for sampling/driving.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk50mhz);
            @(negedge clk50mhz);
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {btn_level, btn_press, btn_release, btn_repeat};
    endfunction

    initial begin
        logic [1:0] exp_rpt;

        // 1: reset with both buttons held, then re-debounce after release
        reset     = 1'b0;
        btn_raw   = 2'b11;
        repeat_en = 2'b00;
        step(3);
        chk("reset_outputs", outs(), 8'h00);
        reset = 1'b1;
        step(5);
        chk("post_reset_not_yet", {btn_level, btn_press}, 4'b0000);
        step(1);
        chk("post_reset_level", btn_level, 2'b11);
        chk("post_reset_press", btn_press, 2'b11);
        chk("post_reset_repeat", btn_repeat, 2'b11);
        step(1);
        chk("post_reset_strobe_gone", {btn_press, btn_repeat}, 4'b0000);
        btn_raw = 2'b00;
        step(5);
        chk("rel_both_not_yet", {btn_level, btn_release}, 4'b1100);
        step(1);
        chk("rel_both", {btn_level, btn_release}, 4'b0011);
        step(1);
        chk("rel_both_gone", btn_release, 2'b00);

        // 2: 3-cycle glitch on channel 0 is rejected
        btn_raw = 2'b01;
        step(3);
        btn_raw = 2'b00;
        for (int k = 0; k < 10; k++) begin
            chk("glitch_quiet", outs(), 8'h00);
            step(1);
        end

        // 3: channel 0 held without auto-repeat
        btn_raw = 2'b01;
        step(5);
        chk("ch0_not_yet", btn_level, 2'b00);
        step(1);
        chk("ch0_press", {btn_level, btn_press, btn_release, btn_repeat}, 8'b01_01_00_01);
        for (int k = 1; k <= 15; k++) begin
            step(1);
            chk("ch0_held_quiet", {btn_level, btn_press, btn_release, btn_repeat}, 8'b01_00_00_00);
        end
        btn_raw = 2'b00;
        step(5);
        chk("ch0_rel_not_yet", {btn_level, btn_release}, 4'b0100);
        step(1);
        chk("ch0_release", {btn_level, btn_release}, 4'b0001);
        step(1);
        chk("ch0_release_gone", btn_release, 2'b00);

        // 4: channel 1 held with auto-repeat; release lands on a repeat edge
        repeat_en = 2'b10;
        btn_raw   = 2'b10;
        step(6);
        chk("ch1_press", {btn_press, btn_repeat}, 4'b1010);
        for (int k = 1; k <= 38; k++) begin
            step(1);
            exp_rpt = (k >= 8 && k < 32 && (k - 8) % 3 == 0) ? 2'b10 : 2'b00;
            chk("ch1_repeat", btn_repeat, exp_rpt);
            chk("ch1_release", btn_release, (k == 32) ? 2'b10 : 2'b00);
            if (k == 26) btn_raw = 2'b00;
        end

        // 5: release while in DELAY, then a fresh press restarts timing
        btn_raw = 2'b10;
        step(6);
        chk("dly_press", {btn_press, btn_repeat}, 4'b1010);
        btn_raw = 2'b00;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            chk("dly_no_repeat", btn_repeat, 2'b00);
            chk("dly_level", btn_level, (k < 6) ? 2'b10 : 2'b00);
        end
        btn_raw = 2'b10;
        step(6);
        chk("fresh_press", {btn_press, btn_repeat}, 4'b1010);
        for (int k = 1; k <= 8; k++) begin
            step(1);
            chk("fresh_repeat", btn_repeat, (k == 8) ? 2'b10 : 2'b00);
        end
        repeat_en = 2'b00;
        for (int k = 9; k <= 15; k++) begin
            step(1);
            chk("disabled_no_repeat", btn_repeat, 2'b00);
        end
        repeat_en = 2'b10;
        step(4);
        chk("reenable_no_restart", btn_repeat, 2'b00);
        btn_raw = 2'b00;
        step(6);
        chk("fresh_release", btn_release, 2'b10);

        // 6: simultaneous presses, reset mid-repeat, held through reset
        repeat_en = 2'b11;
        btn_raw   = 2'b11;
        step(6);
        chk("dual_press", {btn_press, btn_repeat}, 4'b1111);
        for (int k = 1; k <= 8; k++) begin
            step(1);
            chk("dual_repeat", btn_repeat, (k == 8) ? 2'b11 : 2'b00);
        end
        reset = 1'b0;
        #1;
        chk("async_reset_clear", outs(), 8'h00);
        step(2);
        chk("reset_held_clear", outs(), 8'h00);
        reset = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step(1);
            chk("rst_redebounce_quiet", outs(), 8'h00);
        end
        step(1);
        chk("rst_repress", {btn_level, btn_press, btn_repeat}, 6'b111111);
        for (int k = 1; k <= 8; k++) begin
            step(1);
            chk("rst_repeat_restart", btn_repeat, (k == 8) ? 2'b11 : 2'b00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
